fp_div_iter: RTL and testbench



---
 rtl/fp_div_iter.sv | 181 ++++++++++++++++++
 tb/tb_fp_div_iter.sv | 168 ++++++++++++++++
 2 files changed

// File: rtl/fp_div_iter.sv
// Iterative IEEE-754-style divider: quotient = dividend / divisor.
// Radix-2 restoring mantissa division, one quotient bit per cycle, with
// round-to-nearest-even and special-value handling. Subnormals read as zero.
module fp_div_iter #(
    parameter int EXP_W = 8,
    parameter int MAN_W = 23,
    parameter int W     = 1 + EXP_W + MAN_W
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    input  logic [W-1:0] dividend,
    input  logic [W-1:0] divisor,
    output logic         busy,
    output logic         done,
    output logic [W-1:0] quotient,
    output logic         div_by_zero,
    output logic         invalid,
    output logic         overflow,
    output logic         underflow
);
    localparam int CW = $clog2(MAN_W + 4);
    localparam logic [CW-1:0]    LAST   = CW'(MAN_W + 2);
    localparam logic [EXP_W+1:0] BIAS_X = {3'b000, {(EXP_W-1){1'b1}}};
    localparam logic [EXP_W+1:0] ALL1_X = {2'b00, {EXP_W{1'b1}}};
    localparam logic [W-1:0]     QNAN   = {1'b0, {EXP_W{1'b1}}, 1'b1, {(MAN_W-1){1'b0}}};

    localparam logic [2:0] S_IDLE     = 3'd0;
    localparam logic [2:0] S_CLASSIFY = 3'd1;
    localparam logic [2:0] S_SPECIAL  = 3'd2;
    localparam logic [2:0] S_DIVIDE   = 3'd3;
    localparam logic [2:0] S_ROUND    = 3'd4;
    localparam logic [2:0] S_FINISH   = 3'd5;

    logic [2:0]       state;
    logic [W-1:0]     a_r, b_r, res;
    logic [3:0]       res_flags;   // {invalid, div_by_zero, overflow, underflow}
    logic [MAN_W+1:0] rem;
    logic [MAN_W+2:0] q;
    logic [CW-1:0]    cnt;

    // operand fields and classes
    logic [EXP_W-1:0] ea, eb;
    logic [MAN_W-1:0] fa, fb;
    logic             sgn, a_zero, b_zero, a_inf, b_inf, a_nan, b_nan;
    assign ea  = a_r[W-2 -: EXP_W];
    assign eb  = b_r[W-2 -: EXP_W];
    assign fa  = a_r[MAN_W-1:0];
    assign fb  = b_r[MAN_W-1:0];
    assign sgn = a_r[W-1] ^ b_r[W-1];
    assign a_zero = (ea == '0);
    assign b_zero = (eb == '0);
    assign a_inf  = (ea == '1) && (fa == '0);
    assign b_inf  = (eb == '1) && (fb == '0);
    assign a_nan  = (ea == '1) && (fa != '0);
    assign b_nan  = (eb == '1) && (fb != '0);

    // special-case result selection in priority order
    logic         is_special;
    logic [W-1:0] spec_res;
    logic [3:0]   spec_flags;
    always_comb begin
        is_special = 1'b1;
        spec_flags = 4'b0000;
        spec_res   = '0;
        if (a_nan || b_nan || (a_zero && b_zero) || (a_inf && b_inf)) begin
            spec_res   = QNAN;
            spec_flags = 4'b1000;
        end else if (b_zero) begin
            spec_res   = {sgn, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
            spec_flags = 4'b0100;
        end else if (a_inf) begin
            spec_res   = {sgn, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
        end else if (a_zero || b_inf) begin
            spec_res   = {sgn, {(W-1){1'b0}}};
        end else begin
            is_special = 1'b0;
        end
    end

    // one restoring step: compare, conditionally subtract, shift
    logic [MAN_W+1:0] den, rem_next;
    logic             ge;
    always_comb begin
        den      = {1'b0, 1'b1, fb};
        ge       = (rem >= den);
        rem_next = (ge ? (rem - den) : rem) << 1;
    end

    // normalise, round to nearest even, and range-check the exponent
    logic [MAN_W-1:0] frac_pre;
    logic [MAN_W:0]   frac_rnd;
    logic             guard, sticky, adj, inc, ovf, unf;
    logic [EXP_W+1:0] e;
    logic [W-1:0]     rnd_res;
    always_comb begin
        if (q[MAN_W+2]) begin
            frac_pre = q[MAN_W+1:2];
            guard    = q[1];
            sticky   = q[0] | (rem != '0);
            adj      = 1'b0;
        end else begin
            frac_pre = q[MAN_W:1];
            guard    = q[0];
            sticky   = (rem != '0);
            adj      = 1'b1;
        end
        inc      = guard & (sticky | frac_pre[0]);
        frac_rnd = {1'b0, frac_pre} + {{MAN_W{1'b0}}, inc};
        e        = {2'b00, ea} - {2'b00, eb} + BIAS_X
                   + {{(EXP_W+1){1'b0}}, frac_rnd[MAN_W]}
                   - {{(EXP_W+1){1'b0}}, adj};
        ovf      = ($signed(e) >= $signed(ALL1_X));
        unf      = ($signed(e) <= $signed({(EXP_W+2){1'b0}}));
        if (ovf)
            rnd_res = {sgn, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
        else if (unf)
            rnd_res = {sgn, {(W-1){1'b0}}};
        else
            rnd_res = {sgn, e[EXP_W-1:0], frac_rnd[MAN_W-1:0]};
    end

    // control FSM and datapath registers; the done cycle is spent in IDLE
    // with busy still high so a start there is not taken
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= S_IDLE;
            busy <= 1'b0; done <= 1'b0; quotient <= '0;
            div_by_zero <= 1'b0; invalid <= 1'b0; overflow <= 1'b0; underflow <= 1'b0;
            a_r <= '0; b_r <= '0; res <= '0; res_flags <= '0;
            rem <= '0; q <= '0; cnt <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (busy) begin
                        busy <= 1'b0;
                        done <= 1'b0;
                    end else if (start) begin
                        a_r <= dividend;
                        b_r <= divisor;
                        busy <= 1'b1;
                        div_by_zero <= 1'b0; invalid <= 1'b0;
                        overflow <= 1'b0; underflow <= 1'b0;
                        state <= S_CLASSIFY;
                    end
                end
                S_CLASSIFY: begin
                    if (is_special) begin
                        res       <= spec_res;
                        res_flags <= spec_flags;
                        state     <= S_SPECIAL;
                    end else begin
                        rem   <= {1'b0, 1'b1, fa};
                        q     <= '0;
                        cnt   <= '0;
                        state <= S_DIVIDE;
                    end
                end
                S_SPECIAL: state <= S_FINISH;
                S_DIVIDE: begin
                    rem <= rem_next;
                    q   <= {q[MAN_W+1:0], ge};
                    cnt <= cnt + 1'b1;
                    if (cnt == LAST) state <= S_ROUND;
                end
                S_ROUND: begin
                    res       <= rnd_res;
                    res_flags <= {2'b00, ovf, unf};
                    state     <= S_FINISH;
                end
                S_FINISH: begin
                    quotient <= res;
                    {invalid, div_by_zero, overflow, underflow} <= res_flags;
                    done  <= 1'b1;
                    state <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_fp_div_iter.sv
// Scoreboard bench for fp_div_iter: single-precision and half-precision
// instances, directed vectors with hand-computed results and latencies.
module tb_fp_div_iter;
    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    // single precision instance
    logic        s_start, s_busy, s_done, s_dbz, s_inv, s_ovf, s_unf;
    logic [31:0] s_a, s_b, s_q;
    fp_div_iter u_s (
        .clk(clk), .rst(rst), .start(s_start), .dividend(s_a), .divisor(s_b),
        .busy(s_busy), .done(s_done), .quotient(s_q), .div_by_zero(s_dbz),
        .invalid(s_inv), .overflow(s_ovf), .underflow(s_unf)
    );

    // half precision instance
    logic        h_start, h_busy, h_done, h_dbz, h_inv, h_ovf, h_unf;
    logic [15:0] h_a, h_b, h_q;
    fp_div_iter #(.EXP_W(5), .MAN_W(10)) u_h (
        .clk(clk), .rst(rst), .start(h_start), .dividend(h_a), .divisor(h_b),
        .busy(h_busy), .done(h_done), .quotient(h_q), .div_by_zero(h_dbz),
        .invalid(h_inv), .overflow(h_ovf), .underflow(h_unf)
    );

    typedef struct {
        string       name;
        logic [31:0] q;
        logic [3:0]  f;     // {invalid, div_by_zero, overflow, underflow}
        int          lat;
        longint      t0;    // time of the start-sampling edge
    } exp_t;

    exp_t sq[$];
    exp_t hq[$];
    int checks = 0;
    int fails  = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
        checks++;
        if (act !== expv) begin
            fails++;
            $display("FAIL %s: got %h expected %h", name, act, expv);
        end
    endtask

    // single-precision monitor
    exp_t se;
    always @(negedge clk) begin
        if (!rst && s_done) begin
            if (sq.size() == 0) begin
                chk("s_unexpected_done", 32'd1, 32'd0);
            end else begin
                se = sq.pop_front();
                chk({se.name, " quotient"}, s_q, se.q);
                chk({se.name, " flags"}, {28'd0, s_inv, s_dbz, s_ovf, s_unf}, {28'd0, se.f});
                chk({se.name, " latency"}, 32'(($time - 5 - se.t0) / 10), 32'(se.lat));
                chk({se.name, " busy_at_done"}, {31'd0, s_busy}, 32'd1);
            end
        end
    end

    // half-precision monitor
    exp_t he;
    always @(negedge clk) begin
        if (!rst && h_done) begin
            if (hq.size() == 0) begin
                chk("h_unexpected_done", 32'd1, 32'd0);
            end else begin
                he = hq.pop_front();
                chk({he.name, " quotient"}, {16'd0, h_q}, he.q);
                chk({he.name, " flags"}, {28'd0, h_inv, h_dbz, h_ovf, h_unf}, {28'd0, he.f});
                chk({he.name, " latency"}, 32'(($time - 5 - he.t0) / 10), 32'(he.lat));
            end
        end
    end

    task automatic wait_idle();
        int n = 0;
        while ((sq.size() != 0 || hq.size() != 0 || s_busy || h_busy) && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (n >= 200) chk("idle_timeout", 32'd1, 32'd0);
    endtask

    task automatic issue_s(input string n, input logic [31:0] a, input logic [31:0] b,
                           input logic [31:0] q, input logic [3:0] f, input int lat);
        exp_t x;
        wait_idle();
        s_a = a; s_b = b; s_start = 1'b1;
        x.name = n; x.q = q; x.f = f; x.lat = lat; x.t0 = longint'($time) + 5;
        sq.push_back(x);
        @(negedge clk);
        s_start = 1'b0;
    endtask

    task automatic issue_h(input string n, input logic [15:0] a, input logic [15:0] b,
                           input logic [15:0] q, input logic [3:0] f, input int lat);
        exp_t x;
        wait_idle();
        h_a = a; h_b = b; h_start = 1'b1;
        x.name = n; x.q = {16'd0, q}; x.f = f; x.lat = lat; x.t0 = longint'($time) + 5;
        hq.push_back(x);
        @(negedge clk);
        h_start = 1'b0;
    endtask

    initial begin
        int lowcnt;
        rst = 1'b1;
        s_start = 1'b0; s_a = '0; s_b = '0;
        h_start = 1'b0; h_a = '0; h_b = '0;
        @(negedge clk); @(negedge clk);
        chk("reset s_state", {s_busy, s_done, s_dbz, s_inv, s_ovf, s_unf} , 32'd0);
        chk("reset s_quotient", s_q, 32'd0);
        chk("reset h_state", {h_busy, h_done, h_q}, 32'd0);
        rst = 1'b0;
        @(negedge clk);

        // basic op, busy must stay high until the result is taken
        issue_s("six_by_two", 32'h40C00000, 32'h40000000, 32'h40400000, 4'b0000, 29);
        lowcnt = 0;
        for (int i = 0; i < 40 && sq.size() != 0; i++) begin
            if (!s_busy) lowcnt++;
            @(negedge clk);
        end
        chk("busy_throughout", 32'(lowcnt), 32'd0);

        issue_s("one_third", 32'h3F800000, 32'h40400000, 32'h3EAAAAAB, 4'b0000, 29);
        issue_s("neg_one", 32'hBF800000, 32'h3F800000, 32'hBF800000, 4'b0000, 29);
        issue_s("one_by_zero", 32'h3F800000, 32'h00000000, 32'h7F800000, 4'b0100, 3);
        issue_s("zero_by_zero", 32'h00000000, 32'h00000000, 32'h7FC00000, 4'b1000, 3);
        issue_s("inf_by_inf", 32'h7F800000, 32'hFF800000, 32'h7FC00000, 4'b1000, 3);
        issue_s("neg_by_inf", 32'hC0000000, 32'h7F800000, 32'h80000000, 4'b0000, 3);
        issue_s("overflow", 32'h7F000000, 32'h3E800000, 32'h7F800000, 4'b0010, 29);
        issue_s("underflow", 32'h00800000, 32'h4B000000, 32'h00000000, 4'b0001, 29);

        // start and operand changes mid-operation must not disturb the result
        issue_s("ignore_start", 32'h40C00000, 32'h40000000, 32'h40400000, 4'b0000, 29);
        repeat (9) @(negedge clk);
        s_a = 32'h3F800000; s_b = 32'h00000000; s_start = 1'b1;
        @(negedge clk);
        s_start = 1'b0;

        // reset mid-operation aborts with outputs cleared and no done
        issue_s("aborted", 32'h3F800000, 32'h40400000, 32'h3EAAAAAB, 4'b0000, 29);
        repeat (11) @(negedge clk);
        rst = 1'b1;
        #1;
        chk("abort s_state", {s_busy, s_done, s_dbz, s_inv, s_ovf, s_unf}, 32'd0);
        chk("abort s_quotient", s_q, 32'd0);
        sq.delete();
        @(negedge clk);
        rst = 1'b0;
        repeat (40) @(negedge clk);

        issue_s("after_reset", 32'h3F800000, 32'h40400000, 32'h3EAAAAAB, 4'b0000, 29);

        issue_h("half_three", 16'h4600, 16'h4000, 16'h4200, 4'b0000, 16);
        issue_h("half_third", 16'h3C00, 16'h4200, 16'h3555, 4'b0000, 16);

        wait_idle();
        repeat (3) @(negedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
        $finish;
    end
endmodule
